// File: rtl/traffic_controller_gen_if.sv
// Sensor inputs and lamp/status outputs of the two-road traffic controller.
interface traffic_controller_gen_if;
  logic       sb;
  logic       ped_req;
  logic       emg;
  logic [1:0] a;
  logic [1:0] b;
  logic       walk;
  logic [2:0] state;
  logic       preempt_active;

  modport master (
    output sb, ped_req, emg,
    input  a, b, walk, state, preempt_active
  );

  modport slave (
    input  sb, ped_req, emg,
    output a, b, walk, state, preempt_active
  );
endinterface

// File: rtl/traffic_controller_gen.sv
// Two-road traffic controller: main-road rest in green, actuated side phase with
// min/max/gap-out timing, pedestrian walk, all-red clearance and emergency preemption.
module traffic_controller_gen #(
  parameter int unsigned CW         = 10,
  parameter int unsigned T_MAIN_MIN = 4,
  parameter int unsigned T_YEL      = 2,
  parameter int unsigned T_RED      = 1,
  parameter int unsigned T_SIDE_MIN = 3,
  parameter int unsigned T_SIDE_MAX = 8,
  parameter int unsigned T_EXT      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  traffic_controller_gen_if.slave bus
);

  localparam longint unsigned LIM = 64'd1 << CW;
  localparam bit PARAM_OK =
      (T_MAIN_MIN >= 1) && (T_YEL >= 1) && (T_RED >= 1) &&
      (T_SIDE_MIN >= 1) && (T_SIDE_MAX >= 1) && (T_EXT >= 1) &&
      (T_SIDE_MIN <= T_SIDE_MAX) &&
      (64'(T_MAIN_MIN) < LIM) && (64'(T_YEL) < LIM) && (64'(T_RED) < LIM) &&
      (64'(T_SIDE_MIN) < LIM) && (64'(T_SIDE_MAX) < LIM) && (64'(T_EXT) < LIM);

  if (!PARAM_OK) begin : g_bad_param
    $error("traffic_controller_gen: illegal timing parameters");
  end

  localparam logic [CW-1:0] SAT      = '1;
  localparam logic [CW-1:0] MAIN_LST = CW'(T_MAIN_MIN - 1);
  localparam logic [CW-1:0] YEL_LST  = CW'(T_YEL - 1);
  localparam logic [CW-1:0] RED_LST  = CW'(T_RED - 1);
  localparam logic [CW-1:0] SMIN_LST = CW'(T_SIDE_MIN - 1);
  localparam logic [CW-1:0] SMAX_LST = CW'(T_SIDE_MAX - 1);
  localparam logic [CW-1:0] EXT      = CW'(T_EXT);

  typedef enum logic [2:0] {
    MAIN_GREEN = 3'd0,
    MAIN_YEL   = 3'd1,
    RED_1      = 3'd2,
    SIDE_GREEN = 3'd3,
    SIDE_YEL   = 3'd4,
    RED_2      = 3'd5
  } state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] dwell, gap;
  logic          ped_lat;
  logic          call_c, side_entry_c;
  logic [1:0]    a_q, b_q, a_nxt, b_nxt;
  logic          walk_q, walk_nxt, pre_q;

  // Next state and lamp decode of the next state.
  always_comb begin
    state_nxt = state_q;
    a_nxt     = 2'd0;
    b_nxt     = 2'd0;
    walk_nxt  = 1'b0;
    call_c    = bus.sb | ped_lat;
    case (state_q)
      MAIN_GREEN: if (dwell >= MAIN_LST && call_c && !bus.emg) state_nxt = MAIN_YEL;
      MAIN_YEL:   if (dwell == YEL_LST) state_nxt = RED_1;
      RED_1:      if (dwell == RED_LST) state_nxt = bus.emg ? MAIN_GREEN : SIDE_GREEN;
      SIDE_GREEN: if (bus.emg || (dwell >= SMIN_LST && gap >= EXT) || dwell == SMAX_LST)
                    state_nxt = SIDE_YEL;
      SIDE_YEL:   if (dwell == YEL_LST) state_nxt = RED_2;
      RED_2:      if (dwell == RED_LST) state_nxt = MAIN_GREEN;
      default:    state_nxt = MAIN_GREEN;
    endcase
    side_entry_c = (state_nxt == SIDE_GREEN) && (state_q != SIDE_GREEN);
    case (state_nxt)
      MAIN_GREEN: a_nxt = 2'd2;
      MAIN_YEL:   a_nxt = 2'd1;
      SIDE_GREEN: begin
        b_nxt    = 2'd2;
        walk_nxt = 1'b1;
      end
      SIDE_YEL:   b_nxt = 2'd1;
      default:    a_nxt = 2'd0;
    endcase
  end

  // State, timers, pedestrian latch and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MAIN_GREEN;
      dwell   <= '0;
      gap     <= '0;
      ped_lat <= 1'b0;
      a_q     <= 2'd2;
      b_q     <= 2'd0;
      walk_q  <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_nxt != state_q) dwell <= '0;
      else if (dwell != SAT)    dwell <= dwell + CW'(1);
      if (side_entry_c || bus.sb)                    gap <= '0;
      else if (state_q == SIDE_GREEN && gap != SAT)  gap <= gap + CW'(1);
      // Serving the side phase consumes the request, even one arriving this cycle.
      if (side_entry_c)                              ped_lat <= 1'b0;
      else if (bus.ped_req && state_q != SIDE_GREEN) ped_lat <= 1'b1;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      walk_q <= walk_nxt;
      pre_q  <= bus.emg && (state_nxt == MAIN_GREEN);
    end
  end

  assign bus.a              = a_q;
  assign bus.b              = b_q;
  assign bus.walk           = walk_q;
  assign bus.state          = state_q;
  assign bus.preempt_active = pre_q;

endmodule

// File: tb/tb_traffic_controller_gen.sv
// Directed and random checks of traffic_controller_gen against a phase/timer model.
module tb_traffic_controller_gen;

  localparam int TMM = 4, TY = 2, TR = 1, TSN = 3, TSX = 8, TE = 2, SAT = 1023;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  traffic_controller_gen_if bus ();

  traffic_controller_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: current phase, cycles spent in it, idle side cycles, pending pedestrian call.
  int m_st, m_dw, m_gp, m_pl, m_pre;
  int prev_st, run_len;
  int last_len [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_dw = 0; m_gp = 0; m_pl = 0; m_pre = 0;
    prev_st = 0; run_len = 1;
    for (int i = 0; i < 8; i++) last_len[i] = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit e);
    int nx;
    bit call, entry;
    call = s || (m_pl != 0);
    nx = m_st;
    case (m_st)
      0: if (m_dw >= TMM - 1 && call && !e) nx = 1;
      1: if (m_dw == TY - 1) nx = 2;
      2: if (m_dw == TR - 1) nx = e ? 0 : 3;
      3: if (e || (m_dw >= TSN - 1 && m_gp >= TE) || m_dw == TSX - 1) nx = 4;
      4: if (m_dw == TY - 1) nx = 5;
      5: if (m_dw == TR - 1) nx = 0;
      default: nx = 0;
    endcase
    entry = (nx == 3) && (m_st != 3);
    if (entry || s)    m_gp = 0;
    else if (m_st == 3) m_gp = (m_gp < SAT) ? m_gp + 1 : SAT;
    if (entry)                 m_pl = 0;
    else if (p && m_st != 3)   m_pl = 1;
    m_dw  = (nx != m_st) ? 0 : ((m_dw < SAT) ? m_dw + 1 : SAT);
    m_pre = (e && nx == 0) ? 1 : 0;
    m_st  = nx;
  endtask

  task automatic check_all();
    chk("state", 32'(bus.state), m_st);
    chk("lamp_a", 32'(bus.a), (m_st == 0) ? 2 : ((m_st == 1) ? 1 : 0));
    chk("lamp_b", 32'(bus.b), (m_st == 3) ? 2 : ((m_st == 4) ? 1 : 0));
    chk("walk", 32'(bus.walk), (m_st == 3) ? 1 : 0);
    chk("preempt", 32'(bus.preempt_active), m_pre);
  endtask

  task automatic track();
    int cur;
    cur = int'(bus.state);
    if (cur == prev_st) run_len++;
    else begin
      last_len[prev_st & 7] = run_len;
      run_len = 1;
      prev_st = cur & 7;
    end
  endtask

  task automatic cyc(input bit s, input bit p, input bit e);
    bus.sb = s; bus.ped_req = p; bus.emg = e;
    model_step(s, p, e);
    @(negedge clk);
    check_all();
    track();
  endtask

  // Asynchronous reset mid high-phase, held n cycles, released at a falling edge.
  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.sb = 1'b0; bus.ped_req = 1'b0; bus.emg = 1'b0;
    #1;
    chk("async_rst_a", 32'(bus.a), 2);
    chk("async_rst_state", 32'(bus.state), 0);
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b1;
  endtask

  initial begin
    bus.sb = 1'b0; bus.ped_req = 1'b0; bus.emg = 1'b0;
    model_reset();

    // Held in reset for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_a", 32'(bus.a), 2);
      chk("rst_b", 32'(bus.b), 0);
      chk("rst_state", 32'(bus.state), 0);
    end
    rst = 1'b1;

    // Continuous side demand: full max-out cycle.
    for (int i = 1; i <= 22; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("maxout_side_len", last_len[3], 8);
    chk("maxout_myel_len", last_len[1], 2);
    chk("maxout_red1_len", last_len[2], 1);
    chk("maxout_syel_len", last_len[4], 2);
    chk("maxout_red2_len", last_len[5], 1);
    chk("maxout_main_len", last_len[0], 4);

    // Gap-out: side demand drops at side-green dwell 1.
    do_reset(2);
    for (int i = 1; i <= 14; i++) cyc(i <= 8, 1'b0, 1'b0);
    chk("gapout_side_len", last_len[3], 4);

    // Single pedestrian pulse with no vehicles.
    do_reset(2);
    for (int i = 1; i <= 12; i++) cyc(1'b0, i == 1, 1'b0);
    chk("ped_side_len", last_len[3], 3);
    chk("ped_main_len", last_len[0], 4);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("ped_consumed", 32'(bus.state), 0);

    // Emergency during side green ends it at once and holds main green.
    do_reset(2);
    for (int i = 1; i <= 20; i++) cyc(1'b1, 1'b0, i >= 9);
    chk("emg_side_len", last_len[3], 2);
    chk("emg_hold_state", 32'(bus.state), 0);
    chk("emg_hold_preempt", 32'(bus.preempt_active), 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);

    // Emergency during main yellow aborts the side service, pedestrian call kept.
    do_reset(2);
    for (int i = 1; i <= 25; i++) begin
      cyc(i <= 4, i == 1, (i >= 5) && (i <= 10));
      if (i == 7) chk("abort_to_main", 32'(bus.state), 0);
      if (i == 8) chk("abort_preempt", 32'(bus.preempt_active), 1);
    end
    chk("abort_side_served", last_len[3], 3);

    // Random traffic with a mid-run asynchronous reset.
    begin
      bit e_lvl;
      e_lvl = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if (i == 300) do_reset(3);
        if ($urandom_range(0, 29) == 0) e_lvl = ~e_lvl;
        cyc($urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0, e_lvl);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
